ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/lc3b_types.sv | 18 +
 rtl/ifq_fifo.sv | 52 +++++
 rtl/ifetch_queue.sv | 150 +++++++++++++++
 tb/tb_ifetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b front-end types: machine word, cache line, and the fetch queue FSM state.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDiscard
    } ifq_state_t;

    // Pick the 16-bit word addressed by a byte address out of a 128-bit line.
    function automatic lc3b_word line_word(input lc3b_line line, input lc3b_word addr);
        return line[{addr[3:1], 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction queue for ifetch_queue: storage, head/tail pointers and occupancy.
module ifq_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [31:0]            push_data_i,
    input  logic                   pop_i,
    output logic [31:0]            head_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (push_i && !reset_i && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    // A flush wins over any same-cycle push or pop; pointers restart at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding line fetch feeding a small FIFO of {instr, pc}.
// Optional IFETCH_QUEUE_LINE_REUSE_EN keeps the last line to serve sequential fetches locally.
module ifetch_queue
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter lc3b_word    RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ifetch_read,
    output lc3b_word               ifetch_address,
    input  lc3b_line               ifetch_rdata,
    input  logic                   ifetch_resp,
    input  logic                   redirect,
    input  lc3b_word               redirect_pc,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output lc3b_word               deq_instr,
    output lc3b_word               deq_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ifq_state_t  state_q;
    lc3b_word    pc_q;
    lc3b_word    addr_q;
    logic        read_q;

    logic [CW-1:0] count_w;
    logic [31:0]   head_data;
    logic          space;
    logic          fifo_push;
    logic [31:0]   fifo_wdata;
    logic          fifo_pop;
    logic          lb_hit;
    lc3b_word      lb_word;

    assign space = count_w < CW'(DEPTH);

`ifdef IFETCH_QUEUE_LINE_REUSE_EN
    lc3b_line    lb_data_q;
    logic [11:0] lb_tag_q;
    logic        lb_valid_q;

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            lb_valid_q <= 1'b0;
        end else if (state_q == StFetch && ifetch_resp) begin
            lb_valid_q <= 1'b1;
            lb_data_q  <= ifetch_rdata;
            lb_tag_q   <= addr_q[15:4];
        end
    end

    assign lb_hit  = (state_q == StIdle) && lb_valid_q && (lb_tag_q == pc_q[15:4]) && space;
    assign lb_word = line_word(lb_data_q, pc_q);
`else
    assign lb_hit  = 1'b0;
    assign lb_word = '0;
`endif

    // Responses in Discard and anything coincident with a redirect never reach the queue.
    always_comb begin
        fifo_push  = 1'b0;
        fifo_wdata = {line_word(ifetch_rdata, addr_q), addr_q};
        if (!redirect) begin
            if (state_q == StFetch && ifetch_resp) begin
                fifo_push = 1'b1;
            end else if (lb_hit) begin
                fifo_push  = 1'b1;
                fifo_wdata = {lb_word, pc_q};
            end
        end
    end

    assign fifo_pop = deq_valid && deq_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            read_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A redirect empties the queue, so the new fetch can start at once.
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        addr_q  <= redirect_pc;
                        read_q  <= 1'b1;
                        state_q <= StFetch;
                    end else if (lb_hit) begin
                        pc_q <= pc_q + 16'd2;
                    end else if (space) begin
                        addr_q  <= pc_q;
                        read_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (ifetch_resp) begin
                        read_q  <= 1'b0;
                        state_q <= StIdle;
                        pc_q    <= redirect ? redirect_pc : pc_q + 16'd2;
                    end else if (redirect) begin
                        pc_q    <= redirect_pc;
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (ifetch_resp) begin
                        read_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redirect),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_data_o (head_data),
        .count_o     (count_w)
    );

    assign ifetch_read    = read_q;
    assign ifetch_address = addr_q;
    assign deq_valid      = (count_w != '0);
    assign deq_instr      = head_data[31:16];
    assign deq_pc         = head_data[15:0];
    assign count          = count_w;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: memory responder, stream reference model, directed + random.
module tb_ifetch_queue;

    localparam int unsigned DEPTH = 4;
`ifdef IFETCH_QUEUE_LINE_REUSE_EN
    localparam int FILL_RESP = 1;
`else
    localparam int FILL_RESP = 4;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   ifetch_read;
    logic [15:0]            ifetch_address;
    logic [127:0]           ifetch_rdata = '0;
    logic                   ifetch_resp = 1'b0;
    logic                   redirect = 1'b0;
    logic [15:0]            redirect_pc = '0;
    logic                   deq_ready = 1'b0;
    logic                   deq_valid;
    logic [15:0]            deq_instr;
    logic [15:0]            deq_pc;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;
    bit hold = 1'b0;
    int fixed_lat = -1;
    int n_resp = 0;
    int n_line1 = 0;
    int n_deq = 0;

    logic [15:0] exp_q[$];
    logic [15:0] next_pc = '0;
    logic        prev_read = 1'b0;
    logic        prev_resp = 1'b0;
    logic        prev_reset = 1'b1;
    logic [15:0] prev_addr = '0;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ifetch_read    (ifetch_read),
        .ifetch_address (ifetch_address),
        .ifetch_rdata   (ifetch_rdata),
        .ifetch_resp    (ifetch_resp),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Memory image: every byte address maps to a fixed, address-dependent word.
    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] e;
        e = {a[15:1], 1'b0};
        return (e * 16'h9E37) ^ 16'h5A5A ^ {e[7:0], e[15:8]};
    endfunction

    function automatic logic [127:0] line_at(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) begin
            l[16*i +: 16] = word_at({a[15:4], i[2:0], 1'b0});
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 16'd2;
        end
    endtask

    task automatic refill(input logic [15:0] p);
        exp_q.delete();
        next_pc = p;
        top_up();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [15:0] p);
        reset = 1'b1;
        redirect = 1'b0;
        tick(2);
        reset = 1'b0;
        redirect = 1'b1;
        redirect_pc = p;
        tick(1);
        redirect = 1'b0;
    endtask

    // Wait for the current request (if any) to retire, then for the next one to appear.
    task automatic wait_new_req(input logic [15:0] exp, input string name);
        for (int i = 0; i < 60 && ifetch_read; i++) tick(1);
        for (int i = 0; i < 60 && !ifetch_read; i++) tick(1);
        chk(name, ifetch_read ? {16'h0, ifetch_address} : 32'hFFFF_FFFF, {16'h0, exp});
    endtask

    // Memory responder: random or fixed latency, can be held off by the stimulus.
    initial begin
        int age;
        int cur_lat;
        age = 0;
        cur_lat = 0;
        forever begin
            @(posedge clk);
            #2;
            ifetch_resp = 1'b0;
            ifetch_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (reset) begin
                age = 0;
            end else if (ifetch_read) begin
                if (age == 0) begin
                    cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (!hold && age >= cur_lat) begin
                    ifetch_resp = 1'b1;
                    ifetch_rdata = line_at(ifetch_address);
                    age = 0;
                    n_resp++;
                    if (ifetch_address[15:4] == 12'h001) n_line1++;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: the expected stream is pc, pc+2, ... from the last reset/redirect target.
    always @(negedge clk) begin
        logic [15:0] e;
        if (prev_read && !prev_resp && !prev_reset) begin
            chk("req_held_read", 32'(ifetch_read), 32'd1);
            chk("req_held_addr", 32'(ifetch_address), 32'(prev_addr));
        end
        chk("valid_vs_count", 32'(deq_valid), 32'(count != '0));
        chk("count_max", 32'(32'(count) <= DEPTH), 32'd1);
        if (reset) begin
            refill(16'h0000);
        end else if (redirect) begin
            refill(redirect_pc);
        end else if (deq_valid && deq_ready) begin
            e = exp_q.pop_front();
            chk("deq_pc", 32'(deq_pc), 32'(e));
            chk("deq_instr", 32'(deq_instr), 32'(word_at(e)));
            n_deq++;
            top_up();
        end
        prev_read = ifetch_read;
        prev_resp = ifetch_resp;
        prev_reset = reset;
        prev_addr = ifetch_address;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base_deq;
        logic [31:0] r;

        // Reset state, then fill the queue with decode stalled
        reset = 1'b1;
        tick(3);
        chk("rst_read", 32'(ifetch_read), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        fixed_lat = 2;
        base = n_resp;
        reset = 1'b0;
        wait_new_req(16'h0000, "first_req_addr");
        tick(40);
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_read_idle", 32'(ifetch_read), 32'd0);
        chk("fill_resps", n_resp - base, FILL_RESP);
        tick(10);
        chk("full_still_idle", 32'(ifetch_read), 32'd0);
        deq_ready = 1'b1;
        tick(1);
        deq_ready = 1'b0;
`ifdef IFETCH_QUEUE_LINE_REUSE_EN
        tick(6);
        chk("reuse_refill_count", 32'(count), DEPTH);
        chk("reuse_refill_noreq", n_resp - base, 1);
`else
        wait_new_req(16'h0008, "req_after_deq");
`endif
        deq_ready = 1'b1;
        tick(6);

        // Redirect while a request is outstanding: address held, response dropped
        hold = 1'b1;
        fixed_lat = -1;
        restart(16'h0008);
        chk("redir_idle_read", 32'(ifetch_read), 32'd1);
        chk("redir_idle_addr", 32'(ifetch_address), 32'h0008);
        tick(1);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick(1);
        redirect = 1'b0;
        tick(3);
        chk("discard_held_read", 32'(ifetch_read), 32'd1);
        chk("discard_held_addr", 32'(ifetch_address), 32'h0008);
        hold = 1'b0;
        wait_new_req(16'h0040, "req_after_discard");
        tick(12);

        // Redirect coincident with a response and a dequeue
        deq_ready = 1'b0;
        fixed_lat = 1;
        restart(16'h020C);
        for (int i = 0; i < 80 && 32'(count) < 2; i++) tick(1);
        hold = 1'b1;
        for (int i = 0; i < 40 && !ifetch_read; i++) tick(1);
        tick(2);
        chk("pre_redir_count", 32'(count), 32'd2);
        deq_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        hold = 1'b0;
        tick(1);
        redirect = 1'b0;
        deq_ready = 1'b0;
        chk("redir_resp_count", 32'(count), 32'd0);
        wait_new_req(16'h0300, "req_after_redir_resp");
        deq_ready = 1'b1;
        tick(10);

        // PC wraps from 0xFFFE to 0x0000
        fixed_lat = -1;
        restart(16'hFFFE);
        chk("wrap_req_addr", ifetch_read ? {16'h0, ifetch_address} : 32'hFFFF_FFFF, 32'hFFFE);
        wait_new_req(16'h0000, "wrap_next_req");
        tick(20);

`ifdef IFETCH_QUEUE_LINE_REUSE_EN
        // One memory request serves a whole line; a redirect forces a refetch
        restart(16'h0010);
        base = n_line1;
        base_deq = n_deq;
        for (int i = 0; i < 100 && (n_deq - base_deq) < 8; i++) tick(1);
        chk("reuse_deq8", 32'((n_deq - base_deq) >= 8), 32'd1);
        chk("reuse_one_req", n_line1 - base, 1);
        redirect = 1'b1;
        redirect_pc = 16'h0012;
        tick(1);
        redirect = 1'b0;
        for (int i = 0; i < 60 && !(ifetch_read && ifetch_address == 16'h0012); i++) tick(1);
        chk("reuse_redirect_req", ifetch_read ? {16'h0, ifetch_address} : 32'hFFFF_FFFF,
            32'h0012);
        tick(20);
`endif

        // Random traffic against the stream model
        base_deq = n_deq;
        for (int c = 0; c < 3000; c++) begin
            deq_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 599) == 0);
            redirect = ($urandom_range(0, 29) == 0);
            r = $urandom;
            redirect_pc = ($urandom_range(0, 3) == 0) ? {12'hFFF, r[3:1], 1'b0}
                                                      : {r[15:1], 1'b0};
            tick(1);
        end
        reset = 1'b0;
        redirect = 1'b0;
        deq_ready = 1'b1;
        tick(20);
        chk("random_progress", 32'((n_deq - base_deq) > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
